risc_toy_decode_stage: RTL

- Parametrised decode/operand-fetch pipeline stage for the RISC_TOY core, between fetch (IF) and execute (EX).
- Decodes the 5-bit opcode and selects register read addresses, immediates and destination.
- Captures operands from an external two-read-port REGFILE and detects load-use hazards with a stall/bubble.
- Uses valid/ready handshakes on both sides; accepts flush from branch resolution.

---
 rtl/risc_toy_decode_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/risc_toy_decode_stage.sv
// RISC_TOY decode/operand-fetch stage between IF and EX.
// Define RISC_TOY_DEC_FWD_EN to enable EX/MEM operand forwarding; otherwise any pending write stalls.
module risc_toy_decode_stage #(
  parameter int         DW     = 32,
  parameter int         AW     = 5,
  parameter logic [4:0] NOP_OP = 5'b11111
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_VALID,
  output logic          I_READY,
  input  logic [31:0]   INSTR,
  input  logic [29:0]   I_PC,
  output logic [AW-1:0] RA0,
  output logic [AW-1:0] RA1,
  input  logic [DW-1:0] DOUT0,
  input  logic [DW-1:0] DOUT1,
  input  logic          EX_VALID,
  input  logic          EX_WEN,
  input  logic          EX_ISLD,
  input  logic [AW-1:0] EX_DEST,
  input  logic [DW-1:0] EX_RES,
  input  logic          MEM_VALID,
  input  logic          MEM_WEN,
  input  logic [AW-1:0] MEM_DEST,
  input  logic [DW-1:0] MEM_RES,
  input  logic          FLUSH,
  output logic          D_VALID,
  input  logic          D_READY,
  output logic [4:0]    D_OP,
  output logic [DW-1:0] D_VALA,
  output logic [DW-1:0] D_VALB,
  output logic [DW-1:0] D_IMM,
  output logic [AW-1:0] D_DEST,
  output logic          D_WEN,
  output logic [29:0]   D_PC
);
  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // valid never waits on ready, and the payload is held while valid is high and ready low.
  localparam logic [4:0] OP_ADDI = 5'd0,  OP_ANDI = 5'd1,  OP_ORI  = 5'd2,  OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_NEG  = 5'd6,  OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12, OP_SHL  = 5'd13, OP_ROR  = 5'd14, OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16, OP_J    = 5'd17, OP_JL   = 5'd18, OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20, OP_ST   = 5'd21, OP_STR  = 5'd22;

  typedef enum logic [1:0] {B_ZERO, B_FWD, B_RAW, B_SHAMT} b_mode_t;

  function automatic logic [AW-1:0] fit(input logic [4:0] f);
    logic [AW+4:0] t;
    t = {{AW{1'b0}}, f};
    return t[AW-1:0];
  endfunction

  logic [4:0]    op;
  logic [AW-1:0] fa, fb, fc;
  logic [DW-1:0] sext17, zext17, sext22, zext3, zext5;
  logic          a_act, dec_wen, dec_known;
  b_mode_t       b_mode;
  logic [DW-1:0] dec_imm;

  assign op     = INSTR[31:27];
  assign fa     = fit(INSTR[26:22]);
  assign fb     = fit(INSTR[21:17]);
  assign fc     = fit(INSTR[16:12]);
  assign sext17 = {{(DW-17){INSTR[16]}}, INSTR[16:0]};
  assign zext17 = {{(DW-17){1'b0}}, INSTR[16:0]};
  assign sext22 = {{(DW-22){INSTR[21]}}, INSTR[21:0]};
  assign zext3  = {{(DW-3){1'b0}}, INSTR[2:0]};
  assign zext5  = {{(DW-5){1'b0}}, INSTR[4:0]};

  // Port A is the forwarded/hazard-checked source; port B may be active, raw or an immediate.
  always_comb begin
    RA0       = fb;
    RA1       = fa;
    a_act     = 1'b0;
    b_mode    = B_ZERO;
    dec_imm   = '0;
    dec_wen   = 1'b0;
    dec_known = 1'b1;
    case (op)
      OP_ADDI, OP_LD:  begin a_act = 1'b1; b_mode = B_RAW; dec_imm = sext17; dec_wen = 1'b1; end
      OP_ANDI, OP_ORI: begin a_act = 1'b1; b_mode = B_RAW; dec_imm = zext17; dec_wen = 1'b1; end
      OP_ST:           begin a_act = 1'b1; b_mode = B_FWD; dec_imm = sext17; end
      OP_MOVI:         begin dec_imm = sext17; dec_wen = 1'b1; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        RA1 = fc; a_act = 1'b1; b_mode = B_FWD; dec_wen = 1'b1;
      end
      OP_NEG, OP_NOT:  begin RA0 = fc; a_act = 1'b1; dec_wen = 1'b1; end
      OP_LSR, OP_ASR, OP_SHL, OP_ROR: begin
        RA1 = fc; a_act = 1'b1; b_mode = INSTR[5] ? B_FWD : B_SHAMT; dec_wen = 1'b1;
      end
      OP_BR, OP_BRL: begin
        RA1 = fc; a_act = 1'b1; b_mode = B_FWD; dec_imm = zext3; dec_wen = (op == OP_BRL);
      end
      OP_J, OP_JL:     begin dec_imm = sext22; dec_wen = (op == OP_JL); end
      OP_LDR:          begin b_mode = B_RAW; dec_imm = sext22; dec_wen = 1'b1; end
      OP_STR:          begin b_mode = B_FWD; dec_imm = sext22; end
      default:         dec_known = 1'b0;
    endcase
  end

  logic          ex_hit0, ex_hit1, mem_hit0, mem_hit1, b_act;
  logic          stall0, stall1, stall, adv;
  logic [DW-1:0] val0, val1, vala, valb;

  assign b_act    = (b_mode == B_FWD);
  assign ex_hit0  = EX_VALID & EX_WEN & (EX_DEST == RA0);
  assign ex_hit1  = EX_VALID & EX_WEN & (EX_DEST == RA1);
  assign mem_hit0 = MEM_VALID & MEM_WEN & (MEM_DEST == RA0);
  assign mem_hit1 = MEM_VALID & MEM_WEN & (MEM_DEST == RA1);

`ifdef RISC_TOY_DEC_FWD_EN
  assign stall0 = a_act & ex_hit0 & EX_ISLD;
  assign stall1 = b_act & ex_hit1 & EX_ISLD;
  assign val0   = ex_hit0 ? EX_RES : (mem_hit0 ? MEM_RES : DOUT0);
  assign val1   = ex_hit1 ? EX_RES : (mem_hit1 ? MEM_RES : DOUT1);
`else
  logic unused_fwd;
  assign unused_fwd = ^{EX_ISLD, EX_RES, MEM_RES};
  assign stall0 = a_act & (ex_hit0 | mem_hit0);
  assign stall1 = b_act & (ex_hit1 | mem_hit1);
  assign val0   = DOUT0;
  assign val1   = DOUT1;
`endif

  assign stall   = I_VALID & (stall0 | stall1);
  assign adv     = ~D_VALID | D_READY;
  assign I_READY = adv & ~stall & ~FLUSH;
  assign vala    = a_act ? val0 : '0;

  always_comb begin
    valb = '0;
    case (b_mode)
      B_FWD:   valb = val1;
      B_RAW:   valb = DOUT1;
      B_SHAMT: valb = zext5;
      default: valb = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      D_VALID <= 1'b0;
      D_OP    <= NOP_OP;
      D_VALA  <= '0;
      D_VALB  <= '0;
      D_IMM   <= '0;
      D_DEST  <= '0;
      D_WEN   <= 1'b0;
      D_PC    <= '0;
    end else if (FLUSH) begin
      D_VALID <= 1'b0;
    end else if (adv) begin
      // A stalled instruction leaves a bubble and is re-decoded with fresh operands.
      D_VALID <= I_VALID & ~stall;
      if (I_VALID & ~stall) begin
        D_OP   <= dec_known ? op : NOP_OP;
        D_VALA <= vala;
        D_VALB <= valb;
        D_IMM  <= dec_imm;
        D_DEST <= dec_known ? fa : '0;
        D_WEN  <= dec_wen;
        D_PC   <= I_PC;
      end
    end
  end
endmodule
